// File: rtl/sm_accum_if.sv
// Bundle of the sample stream, adder handshake and frame-sum result signals.
// slave is the controller's view; master is the surrounding logic's view.
interface sm_accum_if;
    logic        s_valid;
    logic [23:0] s_data;
    logic        s_ready;
    logic [23:0] add_a;
    logic [23:0] add_b;
    logic        add_en;
    logic [23:0] add_out;
    logic        add_done;
    logic        sum_valid;
    logic [23:0] sum_data;
    logic        err;

    modport slave (
        input  s_valid, s_data, add_out, add_done,
        output s_ready, add_a, add_b, add_en, sum_valid, sum_data, err
    );

    modport master (
        output s_valid, s_data, add_out, add_done,
        input  s_ready, add_a, add_b, add_en, sum_valid, sum_data, err
    );
endinterface

// File: rtl/sm_accum_ctrl.sv
// Frame accumulator for sign-magnitude samples using an external multi-cycle adder.
// Define SMACC_TIMEOUT_EN to abort an adder wait after TIMEOUT_CYC cycles and raise err.
module sm_accum_ctrl #(
    parameter int N_SAMPLES   = 16,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic      clk,
    input  logic      rst,
    sm_accum_if.slave bus
);
    localparam int CNT_W = 8;

    generate
        if (N_SAMPLES < 2 || N_SAMPLES > 255 || TIMEOUT_CYC < 1) begin : g_param_check
            $error("sm_accum_ctrl: N_SAMPLES must be 2..255 and TIMEOUT_CYC >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        EMIT  = 2'd3
    } state_t;

    state_t             state_reg, state_next;
    logic [23:0]        acc_reg, acc_next;
    logic [23:0]        sample_reg, sample_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic [23:0]        sum_data_reg, sum_data_next;
    logic               sum_valid_reg, sum_valid_next;
    logic               timeout_hit;

    logic               overflow;
    logic [23:0]        raw_sum;
    logic [23:0]        corrected;

    // Same-sign addition whose magnitude shrank has wrapped past 23 bits.
    assign overflow  = (acc_reg[23] == sample_reg[23]) &&
                       (bus.add_out[22:0] < acc_reg[22:0]);
    assign raw_sum   = overflow ? {acc_reg[23], 23'h7FFFFF} : bus.add_out;
    assign corrected = (raw_sum[22:0] == 23'd0) ? 24'h000000 : raw_sum;

`ifdef SMACC_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] tmo_reg, tmo_next;
    logic             err_reg, err_next;

    always_comb begin
        tmo_next    = tmo_reg;
        err_next    = err_reg;
        timeout_hit = 1'b0;
        if (state_reg == ISSUE) begin
            tmo_next = '0;
        end else if (state_reg == WAIT && !bus.add_done) begin
            if (tmo_reg == TMO_W'(TIMEOUT_CYC - 1)) begin
                timeout_hit = 1'b1;
                err_next    = 1'b1;
            end else begin
                tmo_next = tmo_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_reg <= '0;
            err_reg <= 1'b0;
        end else begin
            tmo_reg <= tmo_next;
            err_reg <= err_next;
        end
    end

    assign bus.err = err_reg;
`else
    assign timeout_hit = 1'b0;
    assign bus.err     = 1'b0;
`endif

    always_comb begin
        state_next     = state_reg;
        acc_next       = acc_reg;
        sample_next    = sample_reg;
        count_next     = count_reg;
        sum_data_next  = sum_data_reg;
        sum_valid_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.s_valid) begin
                    sample_next = bus.s_data;
                    state_next  = ISSUE;
                end
            end
            ISSUE: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (bus.add_done) begin
                    acc_next   = corrected;
                    count_next = count_reg + 1'b1;
                    if (count_reg == CNT_W'(N_SAMPLES - 1)) begin
                        state_next = EMIT;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (timeout_hit) begin
                    // The sample is dropped: accumulator and count are left as they were.
                    state_next = IDLE;
                end
            end
            EMIT: begin
                sum_data_next  = acc_reg;
                sum_valid_next = 1'b1;
                acc_next       = '0;
                count_next     = '0;
                state_next     = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            acc_reg       <= '0;
            sample_reg    <= '0;
            count_reg     <= '0;
            sum_data_reg  <= '0;
            sum_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            acc_reg       <= acc_next;
            sample_reg    <= sample_next;
            count_reg     <= count_next;
            sum_data_reg  <= sum_data_next;
            sum_valid_reg <= sum_valid_next;
        end
    end

    // Strobes are masked while rst is high so nothing handshakes during reset.
    assign bus.s_ready   = (state_reg == IDLE) && !rst;
    assign bus.add_en    = (state_reg == ISSUE) && !rst;
    assign bus.sum_valid = sum_valid_reg && !rst;
    assign bus.add_a     = acc_reg;
    assign bus.add_b     = sample_reg;
    assign bus.sum_data  = sum_data_reg;
endmodule

// File: tb/tb_sm_accum_ctrl.sv
// Bench for sm_accum_ctrl: two instances (4- and 2-sample frames), behavioural 2-cycle adders
// and a queue scoreboard of expected frame sums built from an integer reference model.
module tb_sm_accum_ctrl;
    localparam int TMO  = 15;
    localparam int MAXM = 8388607;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   cycle    = 0;
    int   last_accept = 0;

    sm_accum_if bus4();
    sm_accum_if bus2();

    sm_accum_ctrl #(.N_SAMPLES(4), .TIMEOUT_CYC(TMO)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
    sm_accum_ctrl #(.N_SAMPLES(2), .TIMEOUT_CYC(TMO)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // Behavioural sign-magnitude adder: magnitude wraps at 23 bits, ties take the sign of b.
    function automatic logic [23:0] sm_add(input logic [23:0] a, input logic [23:0] b);
        logic [23:0] r;
        if (a[23] == b[23])            r = {a[23], a[22:0] + b[22:0]};
        else if (a[22:0] > b[22:0])    r = {a[23], a[22:0] - b[22:0]};
        else                           r = {b[23], b[22:0] - a[22:0]};
        return r;
    endfunction

    logic [1:0] pipe4 = 2'b00;
    logic [1:0] pipe2 = 2'b00;
    logic       block4 = 1'b0;
    logic       kick4  = 1'b0;

    always @(posedge clk) begin
        pipe4 <= {pipe4[0], bus4.add_en};
        pipe2 <= {pipe2[0], bus2.add_en};
    end

    assign bus4.add_done = (pipe4[1] & ~block4) | kick4;
    assign bus4.add_out  = sm_add(bus4.add_a, bus4.add_b);
    assign bus2.add_done = pipe2[1];
    assign bus2.add_out  = sm_add(bus2.add_a, bus2.add_b);

    // Reference model: exact integer sum clamped to the 23-bit magnitude range.
    function automatic int sm_to_int(input logic [23:0] v);
        int m;
        m = int'({9'd0, v[22:0]});
        return v[23] ? -m : m;
    endfunction

    function automatic logic [23:0] int_to_sm(input int v);
        if (v < 0) return {1'b1, 23'(-v)};
        return {1'b0, 23'(v)};
    endfunction

    function automatic int clamp(input int v);
        if (v > MAXM)  return MAXM;
        if (v < -MAXM) return -MAXM;
        return v;
    endfunction

    int model4 = 0, cnt4 = 0, model2 = 0, cnt2 = 0;
    logic [23:0] exp4[$];
    logic [23:0] exp2[$];
    logic [23:0] e4, e2;
    logic prev_en4 = 1'b0, prev_en2 = 1'b0, prev_sv4 = 1'b0, prev_sv2 = 1'b0;

    function automatic logic ready_of(input int which);
        return (which == 4) ? bus4.s_ready : bus2.s_ready;
    endfunction

    // Scoreboard consumer plus protocol monitors, sampled on the falling edge.
    always @(negedge clk) begin
        if (bus4.sum_valid === 1'b1) begin
            checks++;
            if (exp4.size() == 0 || prev_sv4 === 1'b1) begin
                failures++;
                $display("FAIL sum4_unexpected: sum_valid pulse (data=%h, prev=%b) with %0d pending", bus4.sum_data, prev_sv4, exp4.size());
            end else begin
                e4 = exp4.pop_front();
                if (bus4.sum_data !== e4) begin
                    failures++;
                    $display("FAIL sum4_data: got %h, required %h", bus4.sum_data, e4);
                end
            end
`ifndef SMACC_TIMEOUT_EN
            checks++;
            if (bus4.err !== 1'b0) begin
                failures++;
                $display("FAIL err_tied4: got %b, required 0", bus4.err);
            end
`endif
        end
        if (bus2.sum_valid === 1'b1) begin
            checks++;
            if (exp2.size() == 0 || prev_sv2 === 1'b1) begin
                failures++;
                $display("FAIL sum2_unexpected: sum_valid pulse (data=%h, prev=%b) with %0d pending", bus2.sum_data, prev_sv2, exp2.size());
            end else begin
                e2 = exp2.pop_front();
                if (bus2.sum_data !== e2) begin
                    failures++;
                    $display("FAIL sum2_data: got %h, required %h", bus2.sum_data, e2);
                end
            end
        end
        if (bus4.add_en === 1'b1) begin
            checks++;
            if (prev_en4 === 1'b1) begin
                failures++;
                $display("FAIL add_en4_width: add_en high on two consecutive cycles, required single pulse");
            end
        end
        if (bus2.add_en === 1'b1) begin
            checks++;
            if (prev_en2 === 1'b1) begin
                failures++;
                $display("FAIL add_en2_width: add_en high on two consecutive cycles, required single pulse");
            end
        end
        prev_en4 = bus4.add_en;
        prev_en2 = bus2.add_en;
        prev_sv4 = bus4.sum_valid;
        prev_sv2 = bus2.sum_valid;
    end

    task automatic send(input int which, input logic [23:0] d, input bit keep, input bit counted);
        int waited = 0;
        @(negedge clk);
        if (which == 4) begin bus4.s_valid = 1'b1; bus4.s_data = d; end
        else            begin bus2.s_valid = 1'b1; bus2.s_data = d; end
        while (ready_of(which) !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (waited >= 40) begin
            failures++;
            $display("FAIL accept_dut%0d: s_ready=%b after %0d cycles, required 1", which, ready_of(which), waited);
        end else begin
            last_accept = cycle;
            $display("sample dut%0d data=%h cycle=%0d", which, d, cycle);
            if (counted && which == 4) begin
                model4 = clamp(model4 + sm_to_int(d));
                cnt4++;
                if (cnt4 == 4) begin exp4.push_back(int_to_sm(model4)); model4 = 0; cnt4 = 0; end
            end else if (counted) begin
                model2 = clamp(model2 + sm_to_int(d));
                cnt2++;
                if (cnt2 == 2) begin exp2.push_back(int_to_sm(model2)); model2 = 0; cnt2 = 0; end
            end
        end
        @(posedge clk);
        #1;
        if (!keep) begin
            if (which == 4) bus4.s_valid = 1'b0;
            else            bus2.s_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int waited = 0;
        while ((exp4.size() != 0 || exp2.size() != 0) && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (waited >= 100) begin
            failures++;
            $display("FAIL drain: %0d/%0d sums still pending, required 0/0", exp4.size(), exp2.size());
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        bus4.s_valid = 1'b0; bus4.s_data = '0;
        bus2.s_valid = 1'b0; bus2.s_data = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus4.s_ready, bus4.add_en, bus4.sum_valid, bus4.err} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_strobes4: ready/en/valid/err=%b, required 0000", {bus4.s_ready, bus4.add_en, bus4.sum_valid, bus4.err});
        end
        checks++;
        if ({bus4.add_a, bus4.add_b, bus4.sum_data} !== 72'd0) begin
            failures++;
            $display("FAIL reset_data4: add_a=%h add_b=%h sum_data=%h, required all 0", bus4.add_a, bus4.add_b, bus4.sum_data);
        end
        checks++;
        if ({bus2.s_ready, bus2.add_en, bus2.sum_valid, bus2.err, bus2.add_a, bus2.sum_data} !== 52'd0) begin
            failures++;
            $display("FAIL reset_dut2: ready=%b en=%b add_a=%h sum_data=%h, required 0", bus2.s_ready, bus2.add_en, bus2.add_a, bus2.sum_data);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus4.s_ready !== 1'b1 || bus2.s_ready !== 1'b1) begin
            failures++;
            $display("FAIL idle_ready: s_ready=%b/%b, required 1/1", bus4.s_ready, bus2.s_ready);
        end
    endtask

    task automatic test_sum4();
        send(4, 24'h000001, 0, 1);
        send(4, 24'h000002, 0, 1);
        send(4, 24'h000003, 0, 1);
        send(4, 24'h000004, 0, 1);
        send(4, 24'h00000A, 0, 1);
        send(4, 24'h800003, 0, 1);
        send(4, 24'h800014, 0, 1);
        send(4, 24'h000001, 0, 1);
        drain();
    endtask

    task automatic test_neg_zero();
        send(2, 24'h000005, 0, 1);
        send(2, 24'h800005, 0, 1);
        drain();
    endtask

    task automatic test_saturate();
        send(2, 24'h7FFFFF, 0, 1);
        send(2, 24'h000010, 0, 1);
        send(2, 24'hFFFFFF, 0, 1);
        send(2, 24'h800010, 0, 1);
        drain();
    endtask

    task automatic test_back_to_back();
        int prev = 0;
        int gap;
        for (int i = 0; i < 8; i++) begin
            send(4, 24'(i + 1), 1, 1);
            if (i > 0) begin
                gap = (i % 4 == 0) ? 5 : 4;
                checks++;
                if (last_accept - prev !== gap) begin
                    failures++;
                    $display("FAIL accept_gap[%0d]: got %0d cycles, required %0d", i, last_accept - prev, gap);
                end
            end
            prev = last_accept;
        end
        bus4.s_valid = 1'b0;
        drain();
    endtask

    task automatic test_random();
        logic [23:0] d;
        for (int i = 0; i < 6; i++) begin
            d = {1'($urandom_range(0, 1)), 23'($urandom_range(0, MAXM))};
            send(2, d, 0, 1);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        send(2, 24'h000009, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (bus2.add_a !== 24'd0 || bus2.add_b !== 24'd0 || bus2.s_ready !== 1'b1) begin
            failures++;
            $display("FAIL midreset_state: add_a=%h add_b=%h ready=%b, required 0/0/1", bus2.add_a, bus2.add_b, bus2.s_ready);
        end
        @(negedge clk);
        checks++;
        if (bus2.add_a !== 24'd0 || bus2.sum_valid !== 1'b0 || bus2.s_ready !== 1'b1) begin
            failures++;
            $display("FAIL stray_done: add_a=%h sum_valid=%b ready=%b, required 0/0/1", bus2.add_a, bus2.sum_valid, bus2.s_ready);
        end
        send(2, 24'h000003, 0, 1);
        send(2, 24'h000004, 0, 1);
        drain();
    endtask

`ifdef SMACC_TIMEOUT_EN
    task automatic test_timeout();
        block4 = 1'b1;
        send(4, 24'h000033, 0, 0);
        @(negedge clk);
        repeat (TMO) @(negedge clk);
        checks++;
        if (bus4.err !== 1'b0) begin
            failures++;
            $display("FAIL timeout_early: err=%b one cycle before limit, required 0", bus4.err);
        end
        @(negedge clk);
        checks++;
        if (bus4.err !== 1'b1 || bus4.s_ready !== 1'b1) begin
            failures++;
            $display("FAIL timeout_hit: err=%b ready=%b, required 1/1", bus4.err, bus4.s_ready);
        end
        block4 = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (bus4.err !== 1'b1) begin
            failures++;
            $display("FAIL err_sticky: got %b, required 1", bus4.err);
        end
        send(4, 24'h000002, 0, 1);
        send(4, 24'h000002, 0, 1);
        send(4, 24'h000002, 0, 1);
        send(4, 24'h000002, 0, 1);
        drain();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus4.err !== 1'b0) begin
            failures++;
            $display("FAIL err_clear: got %b after rst, required 0", bus4.err);
        end
    endtask
`else
    task automatic test_timeout();
        block4 = 1'b1;
        send(4, 24'h000006, 0, 1);
        repeat (3 * TMO) @(negedge clk);
        checks++;
        if (bus4.s_ready !== 1'b0 || bus4.err !== 1'b0) begin
            failures++;
            $display("FAIL wait_forever: ready=%b err=%b, required 0/0", bus4.s_ready, bus4.err);
        end
        kick4 = 1'b1;
        @(negedge clk);
        kick4  = 1'b0;
        block4 = 1'b0;
        send(4, 24'h000007, 0, 1);
        send(4, 24'h000008, 0, 1);
        send(4, 24'h000009, 0, 1);
        drain();
    endtask
`endif

    initial begin
        bus4.s_valid = 1'b0; bus4.s_data = '0;
        bus2.s_valid = 1'b0; bus2.s_data = '0;
        test_reset();
        test_sum4();
        test_neg_zero();
        test_saturate();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
